reg_bank_sb: RTL and testbench

REG_BANK_SB -- requirements
Module: reg_bank_sb

---
 rtl/reg_bank_sb.sv | 129 ++++++++++++
 tb/tb_reg_bank_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: 2^ADDR_W x DATA_W register file with one write port, two combinational
// read ports, a pending-write scoreboard (busy bits) and a sequential clear sweep.
//
// Ports:
//   clk_i                  clock, all state updates on rising edge
//   reset_ni               synchronous active-low reset
//   wr_en_i/wr_addr_i/wr_data_i   write port; a write also clears the entry's busy bit
//   rd_addr1_i/rd_addr2_i  read addresses
//   rd_data1_o/rd_data2_o  combinational read data (optional write bypass)
//   rsv_en_i/rsv_addr_i    reserve: mark an entry pending
//   busy1_o/busy2_o        pending flag of the read addresses
//   clr_start_i            start a sweep that zeroes one entry per cycle
//   clr_busy_o             high while the sweep runs
// Entry 0 is hard-wired to zero and never pending.

module reg_bank_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              busy1_o,
  output logic              busy2_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   mem_d [Depth];
  logic [Depth-1:0]    busy_q, busy_d;

  logic wr_ok, rsv_ok, byp_ok;

  // Requests are only honoured in idle; a sweep drops them.
  assign wr_ok  = (state_q == StIdle) && wr_en_i && (wr_addr_i != '0);
  assign rsv_ok = (state_q == StIdle) && rsv_en_i && (rsv_addr_i != '0);
  assign byp_ok = (BYPASS != 0) && wr_ok;

  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (wr_ok) begin
          mem_d[wr_addr_i]  = wr_data_i;
          busy_d[wr_addr_i] = 1'b0;
        end
        // Applied after the write so a same-address reserve wins.
        if (rsv_ok) begin
          busy_d[rsv_addr_i] = 1'b1;
        end
        if (clr_start_i) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        mem_d[cnt_q]  = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + 1'b1;  // wraps to 0 after the last entry
        if (cnt_q == '1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    rd_data1_o = '0;
    busy1_o    = 1'b0;
    if (rd_addr1_i != '0) begin
      if (byp_ok && (wr_addr_i == rd_addr1_i)) begin
        rd_data1_o = wr_data_i;
      end else begin
        rd_data1_o = mem_q[rd_addr1_i];
        busy1_o    = busy_q[rd_addr1_i];
      end
    end
  end

  always_comb begin
    rd_data2_o = '0;
    busy2_o    = 1'b0;
    if (rd_addr2_i != '0) begin
      if (byp_ok && (wr_addr_i == rd_addr2_i)) begin
        rd_data2_o = wr_data_i;
      end else begin
        rd_data2_o = mem_q[rd_addr2_i];
        busy2_o    = busy_q[rd_addr2_i];
      end
    end
  end

  assign clr_busy_o = (state_q == StSweep);

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed self-checking bench for reg_bank_sb. Two instances share stimulus: u_dut with
// bypass enabled, u_nb with bypass disabled.

module tb_reg_bank_sb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2, nb_data1, nb_data2;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        busy1, busy2, nb_busy1, nb_busy2;
  logic        clr_start;
  logic        clr_busy, nb_clr_busy;

  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] acc;

  always #5 clk = ~clk;

  reg_bank_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
    .clk_i(clk), .reset_ni(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rd_data1_o(rd_data1), .rd_data2_o(rd_data2), .rsv_en_i(rsv_en),
    .rsv_addr_i(rsv_addr), .busy1_o(busy1), .busy2_o(busy2),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy)
  );

  reg_bank_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nb (
    .clk_i(clk), .reset_ni(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rd_data1_o(nb_data1), .rd_data2_o(nb_data2), .rsv_en_i(rsv_en),
    .rsv_addr_i(rsv_addr), .busy1_o(nb_busy1), .busy2_o(nb_busy2),
    .clr_start_i(clr_start), .clr_busy_o(nb_clr_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; rsv_en = 1'b0; rsv_addr = '0; clr_start = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    rd_addr1 = 5'd5; rd_addr2 = 5'd3;
    #1;
    chk("rst_rd1", rd_data1, 32'h0);
    chk("rst_rd2", rd_data2, 32'h0);
    chk("rst_busy", {30'h0, busy1, busy2}, 32'h0);
    chk("rst_clr_busy", {31'h0, clr_busy}, 32'h0);

    // Plain write and read-back; write to entry 0 ignored.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd0;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd5; #1;
    chk("wr5_rd1", rd_data1, 32'hDEADBEEF);
    chk("wr5_rd1_nb", nb_data1, 32'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr2 = 5'd0;
    tick();
    wr_en = 1'b0; #1;
    chk("wr0_rd2", rd_data2, 32'h0);

    // Simultaneous write+reserve on 7, then a bypassed write to 7.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111; rsv_en = 1'b1; rsv_addr = 5'd7;
    rd_addr1 = 5'd7;
    tick();
    rsv_en = 1'b0; wr_data = 32'hA5A5A5A5; #1;
    chk("byp_data", rd_data1, 32'hA5A5A5A5);
    chk("byp_busy", {31'h0, busy1}, 32'h0);
    chk("nobyp_data", nb_data1, 32'h11111111);
    chk("nobyp_busy", {31'h0, nb_busy1}, 32'h1);
    tick();
    wr_en = 1'b0; #1;
    chk("after_byp", rd_data1, 32'hA5A5A5A5);
    chk("after_byp_busy", {31'h0, busy1}, 32'h0);

    // Scoreboard on entry 3.
    rsv_en = 1'b1; rsv_addr = 5'd3; rd_addr2 = 5'd3;
    tick();
    rsv_en = 1'b0; #1;
    chk("rsv3_busy", {31'h0, busy2}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    wr_en = 1'b0; #1;
    chk("wr3_busy", {31'h0, busy2}, 32'h0);
    chk("wr3_data", rd_data2, 32'h33);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44; rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    wr_en = 1'b0; rsv_en = 1'b0; #1;
    chk("wrrsv3_data", rd_data2, 32'h44);
    chk("wrrsv3_busy", {31'h0, busy2}, 32'h1);
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr2 = 5'd0;
    tick();
    rsv_en = 1'b0; #1;
    chk("rsv0_busy", {31'h0, busy2}, 32'h0);

    // Fill 1..31 and sweep; requests during the sweep are dropped.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h100 + i;
      tick();
    end
    wr_en = 1'b0; rd_addr1 = 5'd31; rd_addr2 = 5'd3; #1;
    chk("fill31", rd_data1, 32'h11F);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF; rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr1 = 5'd9; rd_addr2 = 5'd31; #1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!clr_busy) break;
      n++;
      clr_start = (k == 5);
      if (k == 5) chk("sweep_nobyp9", rd_data1, 32'h109);
      if (k == 20) begin
        chk("sweep_swept9", rd_data1, 32'h0);
        chk("sweep_unswept31", rd_data2, 32'h11F);
      end
      tick();
    end
    wr_en = 1'b0; rsv_en = 1'b0; clr_start = 1'b0; #1;
    chk("sweep_len", n, 32);
    chk("sweep_done", {31'h0, clr_busy}, 32'h0);
    acc = '0;
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); #1;
      acc = acc | rd_data1 | {31'h0, busy1};
    end
    chk("sweep_all_zero", acc, 32'h0);

    // Reset aborts a sweep in progress; a fresh sweep then runs full length.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd6;
    tick();
    wr_en = 1'b0; rsv_en = 1'b0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    chk("pre_rst_clr_busy", {31'h0, clr_busy}, 32'h1);
    reset_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hBAD;
    tick();
    reset_n = 1'b1; wr_en = 1'b0; rd_addr1 = 5'd31; rd_addr2 = 5'd6; #1;
    chk("abort_clr_busy", {31'h0, clr_busy}, 32'h0);
    chk("abort_rd31", rd_data1, 32'h0);
    chk("abort_busy6", {31'h0, busy2}, 32'h0);
    rd_addr1 = 5'd12; #1;
    chk("abort_rd12", rd_data1, 32'h0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0; #1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!clr_busy) break;
      n++;
      tick();
    end
    chk("fresh_sweep_len", n, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
